xcore_bjp_resolve: RTL and testbench
====================================

Name: xcore_bjp_resolve

Overview:
Registered branch/jump resolution unit for the Xcore MEM stage. It is the parametrised successor of the combinational BJP unit. It resolves the conditional-branch direction, jump targets and fence.i from EX-stage ALU results. It detects direction or target mispredictions, holds a flush/redirect request to IF until acknowledged, and emits a 2-bit BPU counter update.

Parameters:
XLEN, 32, datapath/PC width
ID_W, 3, instruction ID width
CNT_W, 16, perf counter width (used only with XCORE_BJP_PERF_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_ex_bjp_req  in  1  valid branch/jump/fence.i from EX
i_ex_br_op  in  3  000 beq, 001 bne, 010 blt, 011 bgt, 100 blte, 101 bgte, 110 jump (jal/jalr), 111 fence.i
i_ex_alu_cmp_res  in  2  bit0 equal, bit1 less-than
i_ex_alu_res  in  XLEN  computed taken target
i_ex_instr_pc  in  XLEN  PC of the instruction
i_ex_instr_deci  in  2  BPU 2-bit counter at predict time
i_ex_pred_target  in  XLEN  target IF used when predicted taken
i_ex_instr_id  in  ID_W  instruction ID
i_if_flush_ack  in  1  IF accepted redirect
o_bjp_busy  out  1  EX must stall; requests are ignored while high
o_bjp_flush_req  out  1  redirect/flush request, held until ack
o_bjp_flush_type  out  1  1 = redirect to taken target, 0 = to pc+4
o_bjp_flush_id  out  ID_W  ID of the flushing instruction
o_bjp_target  out  XLEN  redirect address
o_bjp_res  out  XLEN  pc+4 (link value), registered
o_bpu_upd_vld  out  1  one-cycle BPU update pulse
o_bpu_upd_pc  out  XLEN  PC being updated
o_bpu_upd_cnt  out  2  new saturating counter value

Behaviour:
- Reset: all outputs 0; FSM = IDLE. Reset asserted mid-FLUSH drops the request immediately.
- Taken (conditional ops): beq=eq; bne=~eq; blt=lt; bgt=~lt&~eq; blte=lt|eq; bgte=~lt. Jump op is always taken. fence.i is never a branch.
- pred_taken = i_ex_instr_deci[1].
- Mispredict conditions:
  - fence.i: always, to pc+4.
  - taken != pred_taken.
  - taken & pred_taken & (i_ex_alu_res != i_ex_pred_target).
- Actual target = taken ? i_ex_alu_res : pc+4. All additions are mod 2^XLEN (wrap, no carry out).
- Latency: request accepted in cycle N (IDLE & i_ex_bjp_req). All outputs are valid in cycle N+1.
- FSM:
  - IDLE: on accept with mispredict, go to FLUSH. Set flush_req=1, busy=1, and latch target/type/id.
  - IDLE: on accept with no mispredict, stay in IDLE.
  - FLUSH: hold flush_req and all latched outputs stable. On i_if_flush_ack, go to IDLE; flush_req and busy drop the next cycle.
- busy is combinationally 1 in FLUSH only. Requests seen while busy are ignored, with no update and no count.
- Ack in IDLE is ignored. Ack and a new request in the same FLUSH cycle: return to IDLE, and the request is ignored.
- BPU update, conditional ops only (op<110): upd_vld=1 in cycle N+1 for one cycle.
  - upd_cnt = taken ? sat(deci+1, 3) : sat(deci-1, 0). Saturates at 11 and 00.
  - Jump and fence.i produce no update.
- o_bjp_res = pc+4 is registered on every accept.

Optional Feature:
XCORE_BJP_PERF_EN: adds outputs o_perf_br_cnt and o_perf_mis_cnt (CNT_W each).
- o_perf_br_cnt increments on every accepted request.
- o_perf_mis_cnt increments on every accepted mispredict.
- Both saturate at all-ones and reset to 0.
Without the macro, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. beq, cmp=01, deci=10, alu_res=pred_target=0x100, pc=0x40 -> no flush; upd_vld=1, upd_cnt=11, o_bjp_res=0x44.
2. bne, cmp=01 (equal), deci=11, pc=0x80 -> flush_req=1, type=0, target=0x84, upd_cnt=10. flush_req is held 3 cycles until ack; cleared the cycle after ack.
3. jump, deci=10, alu_res=0x200, pred_target=0x1FC -> flush, type=1, target=0x200; no BPU update.
4. fence.i, pc=0xFFFF_FFFC -> flush, target=0x0000_0000 (wrap). A new beq asserted during FLUSH is ignored: no upd_vld.
5. Ack and new request in the same FLUSH cycle -> IDLE next cycle, request dropped. Reset asserted in FLUSH -> flush_req=0 and busy=0 immediately.
6. With XCORE_BJP_PERF_EN and CNT_W=2: 5 mispredicting requests -> both counters saturate at 3.

Source files
------------

// File: rtl/xcore_bjp_resolve.sv
// Registered branch/jump/fence.i resolution for the MEM stage: detects mispredicts,
// holds a flush/redirect until IF acknowledges, and emits 2-bit BPU counter updates.
// Optional perf counters are enabled with the XCORE_BJP_PERF_EN macro.
module xcore_bjp_resolve #(
   parameter int XLEN  = 32,
   parameter int ID_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_ex_bjp_req,
   input  logic [2:0]      i_ex_br_op,
   input  logic [1:0]      i_ex_alu_cmp_res,
   input  logic [XLEN-1:0] i_ex_alu_res,
   input  logic [XLEN-1:0] i_ex_instr_pc,
   input  logic [1:0]      i_ex_instr_deci,
   input  logic [XLEN-1:0] i_ex_pred_target,
   input  logic [ID_W-1:0] i_ex_instr_id,
   input  logic            i_if_flush_ack,
   output logic            o_bjp_busy,
   output logic            o_bjp_flush_req,
   output logic            o_bjp_flush_type,
   output logic [ID_W-1:0] o_bjp_flush_id,
   output logic [XLEN-1:0] o_bjp_target,
   output logic [XLEN-1:0] o_bjp_res,
   output logic            o_bpu_upd_vld,
   output logic [XLEN-1:0] o_bpu_upd_pc,
   output logic [1:0]      o_bpu_upd_cnt
`ifdef XCORE_BJP_PERF_EN
   ,
   output logic [CNT_W-1:0] o_perf_br_cnt,
   output logic [CNT_W-1:0] o_perf_mis_cnt
`endif
);

   typedef enum logic {S_IDLE, S_FLUSH} state_e;

   state_e            state_q, state_d;
   logic              accept;
   logic              eq, lt, taken, pred_taken, is_fence, is_cond, mispred;
   logic [XLEN-1:0]   pc_plus4, act_target;
   logic [1:0]        new_cnt;

   logic              flush_type_q, flush_type_d;
   logic [ID_W-1:0]   flush_id_q, flush_id_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              upd_vld_q, upd_vld_d;
   logic [XLEN-1:0]   upd_pc_q, upd_pc_d;
   logic [1:0]        upd_cnt_q, upd_cnt_d;

   assign accept     = (state_q == S_IDLE) & i_ex_bjp_req;
   assign eq         = i_ex_alu_cmp_res[0];
   assign lt         = i_ex_alu_cmp_res[1];
   assign pred_taken = i_ex_instr_deci[1];
   assign is_fence   = (i_ex_br_op == 3'b111);
   assign is_cond    = ~(i_ex_br_op[2] & i_ex_br_op[1]);
   assign pc_plus4   = i_ex_instr_pc + XLEN'(4);

   always_comb begin
      taken = 1'b0;
      case (i_ex_br_op)
         3'b000:  taken = eq;
         3'b001:  taken = ~eq;
         3'b010:  taken = lt;
         3'b011:  taken = ~lt & ~eq;
         3'b100:  taken = lt | eq;
         3'b101:  taken = ~lt;
         3'b110:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // fence.i always redirects to pc+4 so the refetch sees the updated I-side
   assign mispred    = is_fence | (taken != pred_taken)
                     | (taken & pred_taken & (i_ex_alu_res != i_ex_pred_target));
   assign act_target = taken ? i_ex_alu_res : pc_plus4;

   always_comb begin
      new_cnt = i_ex_instr_deci;
      if (taken) begin
         if (i_ex_instr_deci != 2'b11) new_cnt = i_ex_instr_deci + 2'd1;
      end else begin
         if (i_ex_instr_deci != 2'b00) new_cnt = i_ex_instr_deci - 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && mispred) state_d = S_FLUSH;
         S_FLUSH: if (i_if_flush_ack)    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      flush_type_d = flush_type_q;
      flush_id_d   = flush_id_q;
      target_d     = target_q;
      res_d        = res_q;
      upd_vld_d    = 1'b0;
      upd_pc_d     = upd_pc_q;
      upd_cnt_d    = upd_cnt_q;
      if (accept) begin
         res_d = pc_plus4;
         if (is_cond) begin
            upd_vld_d = 1'b1;
            upd_pc_d  = i_ex_instr_pc;
            upd_cnt_d = new_cnt;
         end
         if (mispred) begin
            flush_type_d = taken;
            flush_id_d   = i_ex_instr_id;
            target_d     = act_target;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         flush_type_q <= 1'b0;
         flush_id_q   <= '0;
         target_q     <= '0;
         res_q        <= '0;
         upd_vld_q    <= 1'b0;
         upd_pc_q     <= '0;
         upd_cnt_q    <= 2'b00;
      end else begin
         state_q      <= state_d;
         flush_type_q <= flush_type_d;
         flush_id_q   <= flush_id_d;
         target_q     <= target_d;
         res_q        <= res_d;
         upd_vld_q    <= upd_vld_d;
         upd_pc_q     <= upd_pc_d;
         upd_cnt_q    <= upd_cnt_d;
      end
   end

   assign o_bjp_busy       = (state_q == S_FLUSH);
   assign o_bjp_flush_req  = (state_q == S_FLUSH);
   assign o_bjp_flush_type = flush_type_q;
   assign o_bjp_flush_id   = flush_id_q;
   assign o_bjp_target     = target_q;
   assign o_bjp_res        = res_q;
   assign o_bpu_upd_vld    = upd_vld_q;
   assign o_bpu_upd_pc     = upd_pc_q;
   assign o_bpu_upd_cnt    = upd_cnt_q;

`ifdef XCORE_BJP_PERF_EN
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (accept && (br_cnt_q != '1))             br_cnt_d  = br_cnt_q + CNT_W'(1);
      if (accept && mispred && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign o_perf_br_cnt  = br_cnt_q;
   assign o_perf_mis_cnt = mis_cnt_q;
`else
   wire unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_xcore_bjp_resolve.sv
// Directed plus randomized bench for xcore_bjp_resolve against a behavioural model
// that tracks the pending redirect and the expected registered outputs.
module tb_xcore_bjp_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [2:0]  op;
   logic [1:0]  cmp;
   logic [31:0] alu, pc, pred;
   logic [1:0]  deci;
   logic [2:0]  iid;
   logic        ack;

   logic        busy, flush_req, flush_type, upd_vld;
   logic [2:0]  flush_id;
   logic [31:0] target, res, upd_pc;
   logic [1:0]  upd_cnt;
`ifdef XCORE_BJP_PERF_EN
   logic [1:0]  perf_br, perf_mis;
`endif

   int vectors = 0;
   int miscompares = 0;

   // model state
   logic        m_flush, m_type, m_upd_vld;
   logic [2:0]  m_id;
   logic [31:0] m_target, m_res, m_upd_pc;
   logic [1:0]  m_upd_cnt;
   int          m_br, m_mis;

   always #5 clk = ~clk;

   xcore_bjp_resolve #(.XLEN(32), .ID_W(3), .CNT_W(2)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_ex_bjp_req     (req),
      .i_ex_br_op       (op),
      .i_ex_alu_cmp_res (cmp),
      .i_ex_alu_res     (alu),
      .i_ex_instr_pc    (pc),
      .i_ex_instr_deci  (deci),
      .i_ex_pred_target (pred),
      .i_ex_instr_id    (iid),
      .i_if_flush_ack   (ack),
      .o_bjp_busy       (busy),
      .o_bjp_flush_req  (flush_req),
      .o_bjp_flush_type (flush_type),
      .o_bjp_flush_id   (flush_id),
      .o_bjp_target     (target),
      .o_bjp_res        (res),
      .o_bpu_upd_vld    (upd_vld),
      .o_bpu_upd_pc     (upd_pc),
      .o_bpu_upd_cnt    (upd_cnt)
`ifdef XCORE_BJP_PERF_EN
      ,
      .o_perf_br_cnt    (perf_br),
      .o_perf_mis_cnt   (perf_mis)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Branch outcome straight from the ISA meaning of each op
   function automatic logic ref_taken(input logic [2:0] o, input logic [1:0] c);
      logic e, l;
      e = c[0];
      l = c[1];
      case (o)
         3'd0: return e;
         3'd1: return !e;
         3'd2: return l;
         3'd3: return !l && !e;
         3'd4: return l || e;
         3'd5: return !l;
         3'd6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_flush = 0; m_type = 0; m_id = 0; m_target = 0; m_res = 0;
      m_upd_vld = 0; m_upd_pc = 0; m_upd_cnt = 0; m_br = 0; m_mis = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".busy"}, busy, m_flush);
      chk({tag, ".flush_req"}, flush_req, m_flush);
      if (m_flush) begin
         chk({tag, ".target"}, target, m_target);
         chk({tag, ".type"}, flush_type, m_type);
         chk({tag, ".id"}, flush_id, m_id);
      end
      chk({tag, ".res"}, res, m_res);
      chk({tag, ".upd_vld"}, upd_vld, m_upd_vld);
      if (m_upd_vld) begin
         chk({tag, ".upd_pc"}, upd_pc, m_upd_pc);
         chk({tag, ".upd_cnt"}, upd_cnt, m_upd_cnt);
      end
`ifdef XCORE_BJP_PERF_EN
      chk({tag, ".perf_br"}, perf_br, m_br);
      chk({tag, ".perf_mis"}, perf_mis, m_mis);
`endif
   endtask

   task automatic step(input string tag, input logic r, input logic [2:0] o, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] p, input logic [1:0] d,
                       input logic [31:0] pt, input logic [2:0] id_in, input logic k);
      logic accepted, tk, mis;
      req = r; op = o; cmp = c; alu = a; pc = p; deci = d; pred = pt; iid = id_in; ack = k;
      accepted = r && !m_flush;
      if (m_flush && k) m_flush = 0;
      m_upd_vld = 0;
      if (accepted) begin
         tk  = ref_taken(o, c);
         mis = (o == 3'd7) || (tk != d[1]) || (tk && d[1] && (a != pt));
         m_res = p + 32'd4;
         if (o < 3'd6) begin
            m_upd_vld = 1;
            m_upd_pc  = p;
            m_upd_cnt = tk ? ((d == 2'd3) ? 2'd3 : d + 2'd1) : ((d == 2'd0) ? 2'd0 : d - 2'd1);
         end
         if (mis) begin
            m_flush  = 1;
            m_type   = tk;
            m_id     = id_in;
            m_target = tk ? a : p + 32'd4;
         end
         if (m_br < 3) m_br++;
         if (mis && m_mis < 3) m_mis++;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_step(input string tag, input logic k);
      step(tag, 1'b0, 3'd0, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 3'd0, k);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst.flush_req", flush_req, 1'b0);
      chk("rst.busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = 0; op = 0; cmp = 0; alu = 0; pc = 0; deci = 0; pred = 0; iid = 0; ack = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset.target", target, 32'h0);
      chk("reset.type", flush_type, 1'b0);
      chk("reset.id", flush_id, 3'd0);
      chk("reset.upd_pc", upd_pc, 32'h0);
      chk("reset.upd_cnt", upd_cnt, 2'b00);
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: correctly predicted beq
      step("t1_beq", 1, 3'd0, 2'b01, 32'h100, 32'h40, 2'b10, 32'h100, 3'd1, 0);
      chk("t1.upd_cnt_const", upd_cnt, 2'b11);
      chk("t1.res_const", res, 32'h44);

      // 2: bne predicted taken but not taken; flush held for 3 cycles
      step("t2_bne", 1, 3'd1, 2'b01, 32'h300, 32'h80, 2'b11, 32'h300, 3'd2, 0);
      chk("t2.target_const", target, 32'h84);
      chk("t2.cnt_const", upd_cnt, 2'b10);
      idle_step("t2_hold1", 0);
      idle_step("t2_hold2", 0);
      idle_step("t2_ack", 1);
      idle_step("t2_after", 0);

      // 3: jump with wrong predicted target
      step("t3_jump", 1, 3'd6, 2'b00, 32'h200, 32'h60, 2'b10, 32'h1FC, 3'd3, 0);
      chk("t3.type_const", flush_type, 1'b1);
      idle_step("t3_ack", 1);

      // 4: fence.i at top of address space, then a beq during FLUSH
      step("t4_fence", 1, 3'd7, 2'b00, 32'h0, 32'hFFFF_FFFC, 2'b00, 32'h0, 3'd4, 0);
      chk("t4.target_const", target, 32'h0);
      step("t4_ignored", 1, 3'd0, 2'b01, 32'h100, 32'h40, 2'b10, 32'h100, 3'd5, 0);
      idle_step("t4_ack", 1);

      // 5: ack together with a new request, then reset during FLUSH
      step("t5_flush", 1, 3'd2, 2'b10, 32'h500, 32'h90, 2'b01, 32'h0, 3'd6, 0);
      step("t5_ack_req", 1, 3'd2, 2'b10, 32'h500, 32'h90, 2'b01, 32'h0, 3'd7, 1);
      step("t5_flush2", 1, 3'd7, 2'b00, 32'h0, 32'hA0, 2'b00, 32'h0, 3'd1, 0);
      req = 0;
      apply_reset();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] p_r, pt_r, a_r;
         p_r  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         pt_r = $urandom();
         a_r  = ($urandom_range(0, 1) == 0) ? pt_r : $urandom();
         step("rnd", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 2)), a_r, p_r, 2'($urandom_range(0, 3)), pt_r,
              3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      end

      // 6: five mispredicts back to back after a fresh reset
      req = 0;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         step("t6_fence", 1, 3'd7, 2'b00, 32'h0, 32'h1000 + 32'(n * 4), 2'b00, 32'h0, 3'(n), 0);
         idle_step("t6_ack", 1);
      end
`ifdef XCORE_BJP_PERF_EN
      chk("t6.br_sat", perf_br, 2'd3);
      chk("t6.mis_sat", perf_mis, 2'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
